// File: rtl/edge_tick_counter.sv
// -----------------------------------------------------------------------------
// edge_tick_counter
//
// Purpose:
//   Synchronizes the divided-clock signal div_in into the clk domain and emits
//   one-cycle rise_tick / fall_tick pulses for its edges.  A small
//   IDLE/COUNT/DONE controller counts rise_ticks after a start request until
//   the latched target is reached, then pulses done.
//
// Ports:
//   clk        in   1      sole clock, all state on posedge
//   asyn_rst   in   1      asynchronous active-high reset
//   div_in     in   1      divided-clock signal, treated as asynchronous data
//   start      in   1      request to begin a run (accepted only in IDLE)
//   target     in   CNT_W  rising edges to count, sampled when start accepted
//   rise_tick  out  1      one-cycle pulse per synchronized rising edge
//   fall_tick  out  1      one-cycle pulse per synchronized falling edge
//   count      out  CNT_W  rising edges counted in the current or last run
//   busy       out  1      high while counting
//   done       out  1      one-cycle pulse when a run completes
// -----------------------------------------------------------------------------
module edge_tick_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic             clk,
    input  logic             asyn_rst,
    input  logic             div_in,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    // Each state owns at most one bit, so busy and done are single flops
    // and cannot glitch on a COUNT->DONE transition.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic                   prev_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic [CNT_W-1:0]       tgt_reg;
    logic [CNT_W-1:0]       tgt_next;
    logic [CNT_W-1:0]       count_inc;

    // ------------------------------------------------------------------
    // Synchronizer chain and edge detection. Runs regardless of FSM state.
    // ------------------------------------------------------------------
    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], div_in};
            prev_reg <= sync_out;
            rise_reg <= sync_out & ~prev_reg;
            fall_reg <= ~sync_out & prev_reg;
        end
    end

    // ------------------------------------------------------------------
    // Run controller: state, count and latched target registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            tgt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tgt_reg   <= tgt_next;
        end
    end

    assign count_inc = count_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tgt_next   = tgt_reg;
        case (state_reg)
            IDLE: begin
                // A rise_tick coincident with the accepted start is dropped
                // because counting only happens in COUNT.
                if (start) begin
                    tgt_next   = target;
                    count_next = '0;
                    state_next = (target != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                // count < tgt_reg holds throughout COUNT, so the increment
                // can never wrap; the run stops on reaching the target.
                if (rise_reg) begin
                    count_next = count_inc;
                    if (count_inc == tgt_reg) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rise_tick = rise_reg;
    assign fall_tick = fall_reg;
    assign count     = count_reg;
    assign busy      = state_reg[0];
    assign done      = state_reg[1];

endmodule
